cpu0_mem_arbiter: RTL and testbench
===================================

# cpu0_mem_arbiter

Two-port arbiter that shares the single `memory0` port between the cpu0 core (port 0) and a second bus master (port 1: DMA engine or debug loader). It sits between the masters and the memory. It latches one request at a time, drives the memory enable/rw/size/address/data for a fixed access window, captures read data, and returns a one-cycle completion pulse to the winning master. Out-of-range addresses complete with an error and never touch memory.

## Interface
Parameters:
- ACCESS_CYCLES, 1: cycles `m_en` is held high per transaction; legal range 1..15.
- MEM_TOP, 1535: highest legal byte address. A transfer is legal when `addr + bytes(size) - 1 <= MEM_TOP`.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- req0_valid, req1_valid  in  1  request pending; held with fields stable until the matching `done`.
- req0_rw, req1_rw  in  1  1 = read, 0 = write (same encoding as `m_rw`).
- req0_size, req1_size  in  2  00 byte, 01 16-bit, 10 24-bit, 11 32-bit.
- req0_addr, req1_addr  in  32  byte address.
- req0_wdata, req1_wdata  in  32  write data, right-aligned.
- req0_done, req1_done  out  1  one-cycle completion pulse.
- req0_err, req1_err  out  1  valid with `done`; 1 = address out of range.
- req0_rdata, req1_rdata  out  32  read data, valid with `done`; 0 for writes and for errors.
- m_en  out  1  memory enable.
- m_rw  out  1  memory read/write.
- m_size  out  2  memory access size.
- m_addr  out  32  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data; combinational from `memory0`.

## Operation
- FSM states: IDLE, ACCESS, RESP. On reset: state IDLE, all outputs 0, `last_grant` = 1, access counter 0.
- IDLE:
  - If no valid request, remain in IDLE.
  - Otherwise pick a winner, latch its rw/size/addr/wdata into `m_*`, and set `grant_id`.
  - If the address is in range: set `m_en` = 1, load counter with ACCESS_CYCLES-1, and go to ACCESS.
  - If out of range: keep `m_en` = 0, set err, and go directly to RESP.
- ACCESS:
  - `m_en`, `m_rw`, `m_size`, `m_addr`, and `m_wdata` are held stable.
  - The counter decrements each cycle.
  - On the edge where the counter is 0: capture `m_rdata` (masked to `size`, upper bytes 0) if reading, clear `m_en`, and go to RESP.
- RESP:
  - `reqN_done` = 1 for the winner only, with rdata and err valid.
  - `last_grant` ← `grant_id`; next state is IDLE.
  - `m_rw`, `m_size`, `m_addr`, and `m_wdata` keep their last values; only `m_en` is guaranteed low.
- A master still asserting valid in the cycle after `done` is treated as a new request.
- Simultaneous valid requests in IDLE are resolved per Configuration. A lone valid request always wins.
- Address check uses 33-bit arithmetic, so addr near 0xFFFFFFFF does not wrap into range.

## Timing
- All outputs are registered.
- Grant edge E0 (IDLE → ACCESS): `m_en` is high for cycles E0..E0+ACCESS_CYCLES.
- `done` is high in the cycle following edge E0+ACCESS_CYCLES.
- Occupancy is ACCESS_CYCLES+2 cycles per transaction, including the IDLE arbitration cycle.
- Error path: `done` is high in the cycle after E0; `m_en` is never asserted.
- Back-to-back: the earliest next grant is the edge ending RESP+1 (IDLE cycle), so there is no overlap.
- Reset mid-transaction: FSM returns to IDLE and `m_en`/`done` drop immediately (asynchronously). The in-flight write may be partial; no `done` is issued.

## Configuration
- `CPU0_ARB_ROUND_ROBIN_EN` defined: on a simultaneous request, grant the port ≠ `last_grant`. Strict alternation under continuous contention; port 0 wins the first contention after reset.
- Not defined: fixed priority, port 0 always wins. `last_grant` is still tracked, but it is unused for selection.

## Structure
- Shared package `cpu0_mem_pkg`:
  - size encodings BYTE/INT16/INT24/INT32;
  - arbiter state typedef (IDLE/ACCESS/RESP);
  - function `size_bytes(size)` returning 1..4;
  - read-data mask function.
- One sub-module `cpu0_arb_pick`: combinational winner select from (req0_valid, req1_valid, last_grant). Contains the `CPU0_ARB_ROUND_ROBIN_EN` branch.

## Test plan
- Port 0 reads INT32 at addr 0 with memory preloaded 0x12345678, ACCESS_CYCLES = 1 → `m_en` high 1 cycle; `req0_done` pulses 2 cycles after the grant edge with rdata = 0x12345678, err = 0.
- Port 1 writes BYTE 0xAB to addr 100, then reads BYTE at 100 → read returns 0x000000AB. `m_size` = 00 during both accesses.
- Port 0 reads INT32 at addr 1534 (MEM_TOP = 1535) → `req0_done` with err = 1, rdata = 0, `m_en` never asserted, 1-cycle turnaround.
- Both valid continuously for 4 transactions:
  - with `CPU0_ARB_ROUND_ROBIN_EN`, grant order is 0,1,0,1;
  - without it, port 0 wins all 4 and port 1 gets no `done`.
- ACCESS_CYCLES = 3, reset asserted in the 2nd ACCESS cycle → `m_en` = 0 immediately, no `done`. After release, a port 1 request completes normally in 5 cycles.

Source files
------------

// File: rtl/cpu0_mem_pkg.sv
// Shared types and helpers for the cpu0 memory arbiter.
// Size encodings, arbiter states, byte-count and read-mask helpers.
package cpu0_mem_pkg;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    INT16 = 2'b01,
    INT24 = 2'b10,
    INT32 = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] size
  );
    return {1'b0, size} + 3'd1;
  endfunction

  function automatic logic [31:0] rdata_mask(
    input logic [1:0]  size,
    input logic [31:0] data
  );
    logic [31:0] m;
    unique case (size)
      BYTE:    m = 32'h0000_00ff;
      INT16:   m = 32'h0000_ffff;
      INT24:   m = 32'h00ff_ffff;
      default: m = 32'hffff_ffff;
    endcase
    return data & m;
  endfunction

endpackage

// File: rtl/cpu0_mem_arbiter_if.sv
// Request/response and memory bus bundle for the cpu0 arbiter.
// slave: arbiter view; master: requester/memory (bench) view.
interface cpu0_mem_arbiter_if;

  logic        req0_valid;
  logic        req0_rw;
  logic [1:0]  req0_size;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_done;
  logic        req0_err;
  logic [31:0] req0_rdata;

  logic        req1_valid;
  logic        req1_rw;
  logic [1:0]  req1_size;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_done;
  logic        req1_err;
  logic [31:0] req1_rdata;

  logic        m_en;
  logic        m_rw;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  modport slave (
    input  req0_valid, req0_rw, req0_size,
    input  req0_addr, req0_wdata,
    output req0_done, req0_err, req0_rdata,
    input  req1_valid, req1_rw, req1_size,
    input  req1_addr, req1_wdata,
    output req1_done, req1_err, req1_rdata,
    output m_en, m_rw, m_size, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output req0_valid, req0_rw, req0_size,
    output req0_addr, req0_wdata,
    input  req0_done, req0_err, req0_rdata,
    output req1_valid, req1_rw, req1_size,
    output req1_addr, req1_wdata,
    input  req1_done, req1_err, req1_rdata,
    input  m_en, m_rw, m_size, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/cpu0_arb_pick.sv
// Winner select for the cpu0 arbiter.
// CPU0_ARB_ROUND_ROBIN_EN: alternate on contention, else port 0 wins.
module cpu0_arb_pick (
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  output logic win,
  output logic any
);

`ifndef CPU0_ARB_ROUND_ROBIN_EN
  logic pick_unused;
  assign pick_unused = last_grant;
`endif

  always_comb begin
    any = v0 | v1;
    win = 1'b0;
    if (v0 && v1) begin
`ifdef CPU0_ARB_ROUND_ROBIN_EN
      win = ~last_grant;
`else
      win = 1'b0;
`endif
    end else begin
      win = v1;
    end
  end

endmodule

// File: rtl/cpu0_mem_arbiter.sv
// Two-port arbiter sharing memory0 between cpu0 and a second master.
// Optional CPU0_ARB_ROUND_ROBIN_EN selects round-robin contention.
module cpu0_mem_arbiter
  import cpu0_mem_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter int unsigned MEM_TOP       = 1535
) (
  input logic              clock,
  input logic              reset,
  cpu0_mem_arbiter_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  arb_state_e  state, n_state;
  logic        last_grant, n_last;
  logic        grant_id, n_grant;
  logic [3:0]  cnt, n_cnt;
  logic        m_en, n_en;
  logic        m_rw, n_rw;
  logic [1:0]  m_size, n_size;
  logic [31:0] m_addr, n_addr;
  logic [31:0] m_wdata, n_wdata;
  logic [1:0]  done, n_done;
  logic [1:0]  err, n_err;
  logic [31:0] rdata0, n_rdata0;
  logic [31:0] rdata1, n_rdata1;

  logic        win, any;
  logic        sel_rw;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [32:0] last_byte;
  logic        in_range;
  logic [31:0] rd;

  cpu0_arb_pick u_pick (
    .v0         (bus.req0_valid),
    .v1         (bus.req1_valid),
    .last_grant (last_grant),
    .win        (win),
    .any        (any)
  );

  assign sel_rw    = win ? bus.req1_rw    : bus.req0_rw;
  assign sel_size  = win ? bus.req1_size  : bus.req0_size;
  assign sel_addr  = win ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = win ? bus.req1_wdata : bus.req0_wdata;

  // 33-bit sum so addresses near the top of the space cannot wrap
  assign last_byte = {1'b0, sel_addr}
                   + {30'b0, size_bytes(sel_size)}
                   - 33'd1;
  assign in_range  = last_byte <= 33'(MEM_TOP);

  always_comb begin
    n_state  = state;
    n_last   = last_grant;
    n_grant  = grant_id;
    n_cnt    = cnt;
    n_en     = m_en;
    n_rw     = m_rw;
    n_size   = m_size;
    n_addr   = m_addr;
    n_wdata  = m_wdata;
    n_done   = '0;
    n_err    = '0;
    n_rdata0 = '0;
    n_rdata1 = '0;
    rd       = '0;
    unique case (state)
      IDLE: begin
        if (any) begin
          n_grant = win;
          n_rw    = sel_rw;
          n_size  = sel_size;
          n_addr  = sel_addr;
          n_wdata = sel_wdata;
          if (in_range) begin
            n_en    = 1'b1;
            n_cnt   = CNT_LOAD;
            n_state = ACCESS;
          end else begin
            n_done[win] = 1'b1;
            n_err[win]  = 1'b1;
            n_state     = RESP;
          end
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          if (m_rw) rd = rdata_mask(m_size, bus.m_rdata);
          n_en             = 1'b0;
          n_done[grant_id] = 1'b1;
          if (grant_id) n_rdata1 = rd;
          else          n_rdata0 = rd;
          n_state = RESP;
        end else begin
          n_cnt = cnt - 4'd1;
        end
      end
      RESP: begin
        n_last  = grant_id;
        n_state = IDLE;
      end
      default: n_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      cnt        <= '0;
      m_en       <= 1'b0;
      m_rw       <= 1'b0;
      m_size     <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      done       <= '0;
      err        <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state      <= n_state;
      last_grant <= n_last;
      grant_id   <= n_grant;
      cnt        <= n_cnt;
      m_en       <= n_en;
      m_rw       <= n_rw;
      m_size     <= n_size;
      m_addr     <= n_addr;
      m_wdata    <= n_wdata;
      done       <= n_done;
      err        <= n_err;
      rdata0     <= n_rdata0;
      rdata1     <= n_rdata1;
    end
  end

  assign bus.m_en       = m_en;
  assign bus.m_rw       = m_rw;
  assign bus.m_size     = m_size;
  assign bus.m_addr     = m_addr;
  assign bus.m_wdata    = m_wdata;
  assign bus.req0_done  = done[0];
  assign bus.req1_done  = done[1];
  assign bus.req0_err   = err[0];
  assign bus.req1_err   = err[1];
  assign bus.req0_rdata = rdata0;
  assign bus.req1_rdata = rdata1;

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// Bench for cpu0_mem_arbiter: directed steps then random traffic
// checked against a byte-array transaction model.
module tb_cpu0_mem_arbiter;
  import cpu0_mem_pkg::*;

  localparam int AC  = 3;
  localparam int TOP = 1535;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic init_mem = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  cpu0_mem_arbiter_if bus ();

  cpu0_mem_arbiter #(
    .ACCESS_CYCLES (AC),
    .MEM_TOP       (TOP)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem     [0:TOP];
  logic [7:0] ref_mem [0:TOP];

  function automatic logic [7:0] seed_byte(input int i);
    logic [31:0] w;
    w = 32'h1234_5678;
    if (i < 4) return w[8*i +: 8];
    return 8'(i * 37 + 11) ^ 8'(i >> 3);
  endfunction

  always_comb begin
    bus.m_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (longint'(bus.m_addr) + i <= TOP)
        bus.m_rdata[8*i +: 8] = mem[int'(bus.m_addr) + i];
  end

  always @(posedge clock) begin
    if (init_mem) begin
      for (int i = 0; i <= TOP; i++) mem[i] <= seed_byte(i);
    end else if (bus.m_en && !bus.m_rw) begin
      for (int i = 0; i < 4; i++)
        if (i <= int'(bus.m_size) && longint'(bus.m_addr) + i <= TOP)
          mem[int'(bus.m_addr) + i] <= bus.m_wdata[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic model_err(input logic [31:0] a,
                                     input logic [1:0] sz);
    return longint'(a) + longint'(sz) > TOP;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a,
                                             input logic [1:0] sz);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (i <= int'(sz)) r[8*i +: 8] = ref_mem[int'(a) + i];
    return r;
  endfunction

  task automatic set_req(input int p, input logic v, input logic rw,
                         input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_rw = rw; bus.req0_size = sz;
      bus.req0_addr = a; bus.req0_wdata = wd;
    end else begin
      bus.req1_valid = v; bus.req1_rw = rw; bus.req1_size = sz;
      bus.req1_addr = a; bus.req1_wdata = wd;
    end
  endtask

  task automatic txn(input string tag, input int p, input logic rw,
                     input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd);
    logic        e;
    logic [31:0] er, ob_rdata;
    logic        ob_err, my_done, ot_done;
    logic [1:0]  s_size;
    logic [31:0] s_addr;
    int          en_cnt, k_done, other;
    e  = model_err(a, sz);
    er = (!e && rw) ? model_read(a, sz) : 32'h0;
    s_size = ~sz; s_addr = ~a;
    ob_rdata = 'x; ob_err = 1'bx;
    en_cnt = 0; k_done = 0; other = 0;
    @(negedge clock);
    set_req(p, 1'b1, rw, sz, a, wd);
    for (int k = 1; k <= 20 && k_done == 0; k++) begin
      @(negedge clock);
      my_done = p ? bus.req1_done : bus.req0_done;
      ot_done = p ? bus.req0_done : bus.req1_done;
      if (bus.m_en) begin
        en_cnt++; s_size = bus.m_size; s_addr = bus.m_addr;
      end
      if (ot_done) other++;
      if (my_done) begin
        k_done   = k;
        ob_rdata = p ? bus.req1_rdata : bus.req0_rdata;
        ob_err   = p ? bus.req1_err : bus.req0_err;
      end
    end
    set_req(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk({tag, ".latency"}, k_done, e ? 1 : AC + 1);
    chk({tag, ".en_cycles"}, en_cnt, e ? 0 : AC);
    if (!e) begin
      chk({tag, ".m_size"}, s_size, sz);
      chk({tag, ".m_addr"}, s_addr, a);
    end
    chk({tag, ".rdata"}, ob_rdata, er);
    chk({tag, ".err"}, ob_err, e);
    @(negedge clock);
    chk({tag, ".pulse"}, p ? bus.req1_done : bus.req0_done, 1'b0);
    chk({tag, ".other_done"}, other, 0);
    if (!e && !rw)
      for (int i = 0; i <= int'(sz); i++)
        ref_mem[int'(a) + i] = wd[8*i +: 8];
  endtask

  task automatic contend();
    int          exp_p [4];
    int          got_p [4];
    int          got_k [4];
    logic [31:0] got_d [4];
    int          n, lg;
    lg = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef CPU0_ARB_ROUND_ROBIN_EN
      exp_p[i] = 1 - lg;
`else
      exp_p[i] = 0;
`endif
      lg = exp_p[i];
      got_p[i] = -1; got_k[i] = -1; got_d[i] = 'x;
    end
    n = 0;
    @(negedge clock);
    set_req(0, 1'b1, 1'b1, INT32, 32'd8, 32'h0);
    set_req(1, 1'b1, 1'b1, INT32, 32'd16, 32'h0);
    for (int k = 1; k <= 4 * (AC + 2) + 10 && n < 4; k++) begin
      @(negedge clock);
      if (bus.req0_done) begin
        got_p[n] = 0; got_k[n] = k; got_d[n] = bus.req0_rdata; n++;
      end else if (bus.req1_done) begin
        got_p[n] = 1; got_k[n] = k; got_d[n] = bus.req1_rdata; n++;
      end
    end
    set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    chk("contend.count", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("contend.order%0d", i), got_p[i], exp_p[i]);
      chk($sformatf("contend.time%0d", i), got_k[i],
          (i + 1) * (AC + 2) - 1);
      chk($sformatf("contend.rdata%0d", i), got_d[i],
          model_read(exp_p[i] ? 32'd16 : 32'd8, INT32));
    end
    @(negedge clock);
  endtask

  initial begin
    set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i <= TOP; i++) ref_mem[i] = seed_byte(i);
    repeat (3) @(negedge clock);
    chk("reset.m_en", bus.m_en, 1'b0);
    chk("reset.done", {bus.req0_done, bus.req1_done}, 2'b00);
    chk("reset.err", {bus.req0_err, bus.req1_err}, 2'b00);
    chk("reset.rdata0", bus.req0_rdata, 32'h0);
    chk("reset.rdata1", bus.req1_rdata, 32'h0);
    chk("reset.m_addr", bus.m_addr, 32'h0);
    chk("reset.m_wdata", bus.m_wdata, 32'h0);
    chk("reset.m_rw_size", {bus.m_rw, bus.m_size}, 3'b000);
    init_mem = 1'b0;
    reset = 1'b0;

    txn("rd32_0", 0, 1'b1, INT32, 32'd0, 32'h0);
    chk("rd32_0.preload", model_read(32'd0, INT32), 32'h1234_5678);
    txn("wr8_100", 1, 1'b0, BYTE, 32'd100, 32'h0000_00ab);
    txn("rd8_100", 1, 1'b1, BYTE, 32'd100, 32'h0);
    chk("rd8_100.model", model_read(32'd100, BYTE), 32'h0000_00ab);
    txn("oob_1534", 0, 1'b1, INT32, 32'd1534, 32'h0);
    txn("top_1535", 1, 1'b1, BYTE, 32'd1535, 32'h0);
    txn("wrap_ffff", 1, 1'b1, INT16, 32'hffff_ffff, 32'h0);

    contend();

    @(negedge clock);
    set_req(0, 1'b1, 1'b1, INT32, 32'd40, 32'h0);
    @(negedge clock);
    chk("rst_mid.en_before", bus.m_en, 1'b1);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid.m_en", bus.m_en, 1'b0);
    chk("rst_mid.done", {bus.req0_done, bus.req1_done}, 2'b00);
    set_req(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clock);
    chk("rst_mid.hold", {bus.m_en, bus.req0_done}, 2'b00);
    reset = 1'b0;
    txn("after_rst", 1, 1'b1, INT24, 32'd200, 32'h0);

    for (int t = 0; t < 30; t++) begin
      int          p, r;
      logic        rw;
      logic [1:0]  sz;
      logic [31:0] a;
      p  = int'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      r  = int'($urandom_range(0, 9));
      if (r == 0)      a = 32'hffff_ffff - $urandom_range(0, 3);
      else if (r == 1) a = 32'(TOP) - $urandom_range(0, 3);
      else             a = $urandom_range(0, TOP);
      txn($sformatf("rand%0d", t), p, rw, sz, a, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
